// File: rtl/popcount19_weight_gen.sv
// ============================================================================
//  Module      : popcount19_weight_gen
//  Description : Sweeps every 19-bit vector whose Hamming weight equals the
//                requested weight, in strictly ascending order, one word per
//                cycle under back-pressure. It feeds exhaustive checks of
//                popcount19 approximations.
//  Ports       : clk, rst (async, active-high)
//                start, weight[4:0]   - sweep request (sampled only in IDLE)
//                out_ready, abort     - consumer handshake / sweep cancel
//                out_word[18:0], out_valid, out_last - vector stream
//                busy, done, err      - status (done/err are 1-cycle pulses)
//                word_cnt[16:0]       - vectors accepted in current/last sweep
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount19_weight_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  weight,
    input  logic        out_ready,
    input  logic        abort,
    output logic [18:0] out_word,
    output logic        out_valid,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [16:0] word_cnt
);

    localparam int unsigned c_word_w = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_word_w-1:0]   r_last_word;

    logic [c_word_w-1:0]   w_first;
    logic [c_word_w-1:0]   w_last;
    logic [c_word_w-1:0]   w_low;
    logic [c_word_w:0]     w_ripple;
    logic [c_word_w:0]     w_changed;
    logic [4:0]            w_tz;
    logic [5:0]            w_shamt;
    logic [c_word_w-1:0]   w_refill;
    logic [c_word_w-1:0]   w_next;
    logic                  w_xfer;

    // First word has the k ones packed at the bottom, last word at the top.
    assign w_first = 19'((20'd1 << weight) - 20'd1);
    assign w_last  = w_first << (5'd19 - weight);

    // Next larger word of equal weight (Gosper): isolate the lowest set bit,
    // add it to ripple the lowest run of ones upward, then refill the bits
    // that fell out of that run at the bottom. The divide by the isolated bit
    // is a plain right shift by its index.
    assign w_low     = out_word & (~out_word + 19'd1);
    assign w_ripple  = {1'b0, out_word} + {1'b0, w_low};
    assign w_changed = w_ripple ^ {1'b0, out_word};

    always_comb begin
        w_tz = 5'd0;
        for (int i = c_word_w - 1; i >= 0; i--) begin
            if (out_word[i]) begin
                w_tz = 5'(i);
            end
        end
    end

    assign w_shamt  = {1'b0, w_tz} + 6'd2;
    assign w_refill = 19'(w_changed >> w_shamt);
    assign w_next   = w_ripple[c_word_w-1:0] | w_refill;

    assign w_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_word <= '0;
            out_word    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            word_cnt    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (weight > 5'd19) begin
                            err <= 1'b1;
                        end else begin
                            out_word    <= w_first;
                            r_last_word <= w_last;
                            // Weights 0 and 19 have a single word.
                            out_last    <= (w_first == w_last);
                            word_cnt    <= '0;
                            out_valid   <= 1'b1;
                            busy        <= 1'b1;
                            r_state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        word_cnt <= word_cnt + 17'd1;
                        if (!out_last) begin
                            out_word <= w_next;
                            out_last <= (w_next == r_last_word);
                        end
                    end
                    // Final transfer and abort both leave through FIN; a
                    // transfer coinciding with abort is still counted above.
                    if ((w_xfer && out_last) || abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/popcount19_weight_gen.md
POPCOUNT19_WEIGHT_GEN -- requirements
Module: popcount19_weight_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-005 weight  input  5  requested Hamming weight; sampled with start; legal range 0..19.
REQ-006 out_ready  input  1  consumer accepts out_word this cycle.
REQ-007 abort  input  1  synchronous cancel of a running sweep.
REQ-008 out_word  output  19  current test vector, drives a popcount19 input_a.
REQ-009 out_valid  output  1  out_word is valid.
REQ-010 out_last  output  1  out_word is the final vector of the sweep; qualified by out_valid.
REQ-011 busy  output  1  sweep in progress (state RUN).
REQ-012 done  output  1  one-cycle pulse when a sweep finishes or is aborted.
REQ-013 err  output  1  one-cycle pulse when start arrives with weight > 19.
REQ-014 word_cnt  output  17  number of vectors accepted in the current or most recent sweep.

Function
REQ-015 Purpose: enumerate every 19-bit vector whose popcount equals weight, each exactly once, for exhaustive checking of popcount19 approximations.
REQ-016 Order SHALL be strictly ascending unsigned value: first word (1<<k)-1, last word with the k ones in bits 18..19-k.
REQ-017 States SHALL be IDLE, RUN and FIN.
REQ-018 IDLE: start with weight <= 19 -> load first word, clear word_cnt, go to RUN; out_valid rises in the following cycle.
REQ-019 IDLE: start with weight > 19 -> err pulses for one cycle; state, out_word and word_cnt are unchanged.
REQ-020 RUN: out_valid = 1; a transfer occurs when out_valid & out_ready.
REQ-021 On a transfer of a non-last word, out_word SHALL advance to the next weight-k word in the following cycle and word_cnt SHALL increment by 1.
REQ-022 With out_valid=1 and out_ready=0, out_word, out_last and word_cnt SHALL hold stable.
REQ-023 On transfer of the last word, word_cnt increments, out_valid drops in the following cycle and the state goes to FIN.
REQ-024 FIN lasts one cycle, pulses done, then returns to IDLE.
REQ-025 Weight 0 SHALL produce exactly one word 0x00000 with out_last=1; weight 19 SHALL produce exactly one word 0x7FFFF with out_last=1.
REQ-026 Each sweep's final word_cnt SHALL equal C(19,k) (max 92378 at k=9,10); the 17-bit counter SHALL NOT wrap.
REQ-027 The next-word computation SHALL be single-cycle: lowest-set-bit isolate, add, shifted ripple of the changed bits, no multi-cycle divider; throughput SHALL be one word per cycle under continuous out_ready.
REQ-028 start while busy or in FIN SHALL be ignored.
REQ-029 abort in RUN -> FIN next cycle (done pulses, out_valid drops); a transfer in the same cycle as abort is counted; abort in IDLE or FIN has no effect.
REQ-030 All outputs SHALL be registered; out_word SHALL never carry a popcount different from the latched weight while out_valid=1.

Reset
REQ-031 Reset SHALL force IDLE asynchronously, including mid-sweep, with out_word=0, out_valid=0, out_last=0, busy=0, done=0, err=0 and word_cnt=0.
REQ-032 After reset deassertion, the first start SHALL be honoured on the first rising edge at which it is sampled.

Verification
REQ-033 weight=2, out_ready=1 -> words 0x00003, 0x00005, 0x00006, 0x00009, ... last 0x60000; 171 transfers, word_cnt=171, done one cycle after last.
REQ-034 weight=0, and separately weight=19 -> single word 0x00000 (resp. 0x7FFFF) with out_last=1; word_cnt=1.
REQ-035 weight=20 -> err pulse, out_valid never rises, busy stays 0.
REQ-036 weight=1 with out_ready toggled randomly -> words 1,2,4,...,0x40000 in order, stable while stalled, 19 transfers, no duplicates.
REQ-037 weight=9, full sweep with a scoreboard -> 92378 distinct words, each with popcount 9, strictly ascending; then rst asserted mid-second-sweep -> all outputs 0 immediately.
REQ-038 abort after 5 transfers at weight=3 -> done pulse, word_cnt=5, a new start accepted two cycles later.
